uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. It accepts one byte per grant through a valid/ready handshake, drives `uart_tx_start`/`uart_tx_input`, and times each frame internally because `uart_tx` has no busy output. Packet locking keeps a multi-byte message from one requester contiguous on the line. It sits directly in front of `uart_tx`, and `uart_txd` is unchanged.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
`timescale 1ns/1ps
package uart_pkg;

    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } arb_state_t;

    function automatic int frame_cycles(input int clks_per_bit, input int gap);
        return clks_per_bit * FRAME_BITS + gap;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner select: first valid index at or after rr_ptr, wrapping.
`timescale 1ns/1ps
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx, with frame pacing and packet lock.
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int   NUM_REQ      = 4,
    parameter int   CLKS_PER_BIT = 16,
    parameter int   GAP_CYCLES   = 2,
    parameter int   LOCK_TIMEOUT = 256,
    localparam int  IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_input,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 busy,
    output logic                 lock_abort
);

    localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, GAP_CYCLES);
    localparam int FRM_W        = $clog2(FRAME_CYCLES);
    localparam int SIL_W        = $clog2(LOCK_TIMEOUT + 1);

    arb_state_t       state, state_nxt;
    logic [FRM_W-1:0] frame_cnt, frame_nxt;
    logic [SIL_W-1:0] silence, silence_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt;
    logic [IDX_W-1:0] grant_nxt;
    logic [IDX_W-1:0] pick, sel;
    logic             locked, locked_nxt;
    logic             any_valid, accept;
    logic [7:0]       tx_nxt, sel_byte;
    logic [7:0]       req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*8 +: 8];
    end

    assign sel_byte = req_bytes[sel];

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (pick),
        .any_valid (any_valid)
    );

    assign busy          = (state == START) || (state == WAIT);
    assign uart_tx_start = (state == START);

    // Handshake outputs are gated while reset is held so no byte is lost.
    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame_cnt;
        silence_nxt = silence;
        rr_nxt      = rr_ptr;
        grant_nxt   = grant_idx;
        locked_nxt  = locked;
        tx_nxt      = uart_tx_input;
        accept      = 1'b0;
        sel         = pick;
        req_ready   = '0;
        lock_abort  = 1'b0;

        unique case (state)
            IDLE: begin
                accept = any_valid & reset;
            end
            START: begin
                frame_nxt   = FRM_W'(FRAME_CYCLES - 1);
                silence_nxt = '0;
                state_nxt   = WAIT;
            end
            WAIT: begin
                frame_nxt = frame_cnt - 1'b1;
                if (frame_cnt <= FRM_W'(1)) begin
                    state_nxt = locked ? HOLD : IDLE;
                end
            end
            HOLD: begin
                sel = grant_idx;
                if (req_valid[grant_idx]) begin
                    accept = reset;
                end else if (silence == SIL_W'(LOCK_TIMEOUT)) begin
                    lock_abort = reset;
                    locked_nxt = 1'b0;
                    state_nxt  = IDLE;
                end else begin
                    silence_nxt = silence + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (accept) begin
            req_ready[sel] = 1'b1;
            tx_nxt         = sel_byte;
            grant_nxt      = sel;
            rr_nxt         = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            locked_nxt     = ~req_last[sel];
            state_nxt      = START;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            silence       <= '0;
            rr_ptr        <= '0;
            locked        <= 1'b0;
            grant_idx     <= '0;
            uart_tx_input <= 8'h00;
        end else begin
            state         <= state_nxt;
            frame_cnt     <= frame_nxt;
            silence       <= silence_nxt;
            rr_ptr        <= rr_nxt;
            locked        <= locked_nxt;
            grant_idx     <= grant_nxt;
            uart_tx_input <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester streams, start monitor.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } src_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           uart_tx_start;
    logic [7:0]     uart_tx_input;
    logic [1:0]     grant_idx;
    logic           busy;
    logic           lock_abort;

    logic       rv [N] = '{default: 1'b0};
    logic       rl [N] = '{default: 1'b0};
    logic [7:0] rd [N] = '{default: 8'h00};

    assign req_valid = {rv[3], rv[2], rv[1], rv[0]};
    assign req_last  = {rl[3], rl[2], rl[1], rl[0]};
    assign req_data  = {rd[3], rd[2], rd[1], rd[0]};

    src_t src_q [N][$];
    exp_t exp_q [$];
    int   start_log [$];

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [N-1:0] took = '0;
    logic [7:0] held = 8'h00;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .CLKS_PER_BIT (16),
        .GAP_CYCLES   (2),
        .LOCK_TIMEOUT (256)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_start (uart_tx_start),
        .uart_tx_input (uart_tx_input),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .lock_abort    (lock_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_src(input int i, input logic [7:0] d, input logic l);
        src_t s;
        logic [1:0] j;
        j = 2'(i);
        s.data = d;
        s.last = l;
        src_q[j].push_back(s);
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // A transfer seen mid-cycle completes at the following rising edge.
    always @(negedge clk) took = req_valid & req_ready;

    always begin
        logic [1:0] j;
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            j = 2'(i);
            if (took[j] && src_q[j].size() > 0) begin
                void'(src_q[j].pop_front());
            end
            if (src_q[j].size() > 0) begin
                rv[j] = 1'b1;
                rd[j] = src_q[j][0].data;
                rl[j] = src_q[j][0].last;
            end else begin
                rv[j] = 1'b0;
                rl[j] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && uart_tx_start) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_start: got grant %0d byte 0x%0h, expected no start",
                         grant_idx, uart_tx_input);
            end else begin
                e = exp_q.pop_front();
                check("sb_grant_idx", int'(grant_idx), e.idx);
                check("sb_tx_byte", int'(uart_tx_input), int'(e.data));
            end
            start_log.push_back(cyc);
            held = uart_tx_input;
        end else if (busy) begin
            check("tx_input_stable", int'(uart_tx_input), int'(held));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    task automatic drive_at(input int k);
        do tick(); while (cyc < k);
    endtask

    task automatic wait_ready(input int i, input int budget, output int at);
        logic [1:0] j;
        j  = 2'(i);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (req_ready[j]) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check({"drain_", tag}, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_start"}, int'(uart_tx_start), 0);
        check({tag, "_tx_input"}, int'(uart_tx_input), 0);
        check({tag, "_grant_idx"}, int'(grant_idx), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_lock_abort"}, int'(lock_abort), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish before 500 us");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, p, r, t, bp;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        tick();
        reset = 1'b1;

        // Fairness: two rounds from all four requesters.
        tick();
        start_log.delete();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                push_src(i, 8'(16 + i), 1'b1);
                push_exp(i, 8'(16 + i));
            end
        end
        wait_drain("fair", 8 * 163 + 50);
        check("fair_starts", start_log.size(), 8);
        for (int k = 1; k < start_log.size(); k++) begin
            check("fair_spacing", start_log[k] - start_log[k-1], 163);
        end

        // Single byte timing.
        tick();
        p = cyc;
        push_src(0, 8'h34, 1'b1);
        push_exp(0, 8'h34);
        wait_ready(0, 10, a);
        check("single_ready_lat", a, p);
        wait_cyc(a + 1);
        check("single_start", int'(uart_tx_start), 1);
        check("single_busy_first", int'(busy), 1);
        wait_cyc(a + 2);
        check("single_start_pulse", int'(uart_tx_start), 0);
        wait_cyc(a + 162);
        check("single_busy_last", int'(busy), 1);
        wait_cyc(a + 163);
        check("single_busy_clear", int'(busy), 0);
        wait_drain("single", 50);

        // Backpressure: req1 waits through a req0 frame.
        tick();
        push_src(0, 8'hB0, 1'b1);
        push_exp(0, 8'hB0);
        push_exp(1, 8'hB1);
        wait_ready(0, 10, a);
        tick();
        push_src(1, 8'hB1, 1'b1);
        bp = 0;
        for (int c = a + 1; c <= a + 162; c++) begin
            wait_cyc(c);
            if (req_ready[1]) bp++;
        end
        check("bp_ready_held_low", bp, 0);
        wait_cyc(a + 163);
        check("bp_ready_pulse", int'(req_ready), 2);
        wait_cyc(a + 164);
        check("bp_ready_single", int'(req_ready), 0);
        wait_drain("bp", 250);

        // Packet lock: req2 keeps the line for three bytes, then wrap to req0.
        tick();
        push_src(2, 8'h55, 1'b0);
        push_src(2, 8'hAA, 1'b0);
        push_src(2, 8'h0F, 1'b1);
        push_src(0, 8'hA0, 1'b1);
        push_src(1, 8'hA1, 1'b1);
        push_exp(2, 8'h55);
        push_exp(2, 8'hAA);
        push_exp(2, 8'h0F);
        push_exp(0, 8'hA0);
        push_exp(1, 8'hA1);
        wait_drain("lock", 5 * 163 + 50);

        // Lock timeout: req1 goes silent, req3 waits.
        tick();
        push_src(1, 8'h41, 1'b0);
        push_exp(1, 8'h41);
        push_exp(3, 8'h33);
        wait_ready(1, 10, a);
        tick();
        push_src(3, 8'h33, 1'b1);
        t = -1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (lock_abort) begin
                t = cyc;
                break;
            end
        end
        check("abort_cycle", t, a + 419);
        wait_cyc(t + 1);
        check("abort_pulse", int'(lock_abort), 0);
        check("abort_then_grant", int'(req_ready), 8);
        wait_drain("timeout", 250);

        // Reset in the middle of a frame.
        tick();
        push_src(1, 8'hC3, 1'b1);
        push_exp(1, 8'hC3);
        wait_ready(1, 10, a);
        drive_at(a + 50);
        reset = 1'b0;
        wait_cyc(a + 51);
        check_reset("rst_mid1");
        drive_at(a + 52);
        reset = 1'b1;
        wait_cyc(a + 52);
        check_reset("rst_mid2");
        drive_at(a + 53);
        push_src(3, 8'h3C, 1'b1);
        push_exp(3, 8'h3C);
        wait_ready(3, 10, r);
        check("rst_then_accept", r, a + 53);
        wait_drain("rst", 250);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
